// File: rtl/fabric_ingress_arbiter.sv
// Frame-granular round-robin tready steering of NUM_PORTS RX streams onto one fabric datapath; grant 1 cycle after request.
// A frame holds its grant through any stall; one dead cycle between frames; oversize frames drain regardless of dst_ready.
module fabric_ingress_arbiter #(
    parameter  int NUM_PORTS       = 24,
    parameter  int MAX_FRAME_BEATS = 2500,
    localparam int IDX_WIDTH       = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port_en,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] req_last,
    input  logic                 dst_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 drain,
    output logic                 oversize,
    output logic [15:0]          oversize_count
);
    localparam int                   CNT_WIDTH  = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_LEGAL = CNT_WIDTH'(MAX_FRAME_BEATS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d, rr_q, rr_d, winner;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic                 gv_q, gv_d, drain_q, drain_d, ov_q, ov_d;
    logic [15:0]          ovc_q, ovc_d;
    logic [NUM_PORTS-1:0] eligible;
    logic                 any_elig, sel_req, sel_last, fire, dfire, hit_max;

    assign eligible = req & port_en;
    assign sel_req  = req[idx_q];
    assign sel_last = req_last[idx_q];
    assign fire     = gv_q & sel_req & dst_ready;
    assign dfire    = drain_q & sel_req;
    assign hit_max  = (beat_q == LAST_LEGAL);

    // Scan farthest-first so the port nearest after rr_q overwrites and wins.
    always_comb begin
        winner   = rr_q;
        any_elig = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (eligible[IDX_WIDTH'((int'(rr_q) + i) % NUM_PORTS)]) begin
                winner   = IDX_WIDTH'((int'(rr_q) + i) % NUM_PORTS);
                any_elig = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_elig) state_d = BUSY;
            BUSY: begin
                if (fire) begin
                    if (sel_last) begin
                        state_d = IDLE;
                    end else if (hit_max) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   if (dfire && sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Last on the max beat takes the normal end-of-frame path, never oversize.
    always_comb begin
        idx_d   = idx_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        ov_d    = 1'b0;
        ovc_d   = ovc_q;
        gv_d    = (state_d == BUSY);
        drain_d = (state_d == DRAIN);
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    idx_d  = winner;
                    rr_d   = winner;
                    beat_d = '0;
                end
            end
            BUSY: begin
                if (fire) begin
                    beat_d = beat_q + CNT_WIDTH'(1);
                    if (!sel_last && hit_max) begin
                        ov_d = 1'b1;
                        if (ovc_q != 16'hFFFF) ovc_d = ovc_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            rr_q    <= IDX_WIDTH'(NUM_PORTS - 1);
            beat_q  <= '0;
            gv_q    <= 1'b0;
            drain_q <= 1'b0;
            ov_q    <= 1'b0;
            ovc_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            gv_q    <= gv_d;
            drain_q <= drain_d;
            ov_q    <= ov_d;
            ovc_q   <= ovc_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q != IDLE) grant[idx_q] = 1'b1;
    end

    assign grant_idx      = idx_q;
    assign grant_valid    = gv_q;
    assign drain          = drain_q;
    assign oversize       = ov_q;
    assign oversize_count = ovc_q;
endmodule

// File: tb/tb_fabric_ingress_arbiter.sv
// Bench for fabric_ingress_arbiter (24 ports, 8-beat max frame): vector table, directed corner sequences, random traffic vs model.
module tb_fabric_ingress_arbiter;
    localparam int N    = 24;
    localparam int IW   = 5;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  port_en, req, req_last, grant;
    logic          dst_ready;
    logic [IW-1:0] grant_idx;
    logic          grant_valid, drain, oversize;
    logic [15:0]   oversize_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fabric_ingress_arbiter #(.NUM_PORTS(N), .MAX_FRAME_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst), .port_en(port_en), .req(req), .req_last(req_last),
        .dst_ready(dst_ready), .grant(grant), .grant_idx(grant_idx),
        .grant_valid(grant_valid), .drain(drain), .oversize(oversize),
        .oversize_count(oversize_count)
    );

    typedef struct {
        logic [N-1:0]  en, rq, lst;
        logic          rdy;
        logic [N-1:0]  eg;
        logic [IW-1:0] eidx;
        logic          egv, edr, eov;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] en, input logic [N-1:0] rq, input logic [N-1:0] lst,
                                input logic rdy, input logic [N-1:0] eg, input logic [IW-1:0] eidx,
                                input logic egv, input logic edr, input logic eov);
        vec_t v;
        v.en = en; v.rq = rq; v.lst = lst; v.rdy = rdy;
        v.eg = eg; v.eidx = eidx; v.egv = egv; v.edr = edr; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] g, input int idx,
                           input logic gv, input logic dr, input logic ov);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, ".drain"}, 32'(drain), 32'(dr));
        chk({tag, ".oversize"}, 32'(oversize), 32'(ov));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_last = '0; dst_ready = 1'b0; port_en = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: transaction view of the frame being served plus source-side frame bookkeeping.
    int   m_state, m_idx, m_rr, m_beats, m_cnt;
    logic m_ov;
    int   flen[N];
    int   fpos[N];

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_rr = N - 1; m_beats = 0; m_cnt = 0; m_ov = 1'b0;
        for (int p = 0; p < N; p++) begin flen[p] = 0; fpos[p] = 0; end
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        int best;
        m_ov = 1'b0;
        elig = req & port_en;
        if (m_state == 0) begin
            if (elig != '0) begin
                best = -1;
                for (int k = 1; k <= N; k++)
                    if (best < 0 && elig[IW'((m_rr + k) % N)]) best = (m_rr + k) % N;
                m_state = 1; m_idx = best; m_rr = best; m_beats = 0;
            end
        end else if (req[IW'(m_idx)] && (m_state == 2 || dst_ready)) begin
            if (req_last[IW'(m_idx)]) begin
                flen[m_idx] = 0; fpos[m_idx] = 0; m_state = 0;
            end else begin
                fpos[m_idx]++;
                if (m_state == 1) begin
                    m_beats++;
                    if (m_beats == MAXB) begin
                        m_state = 2; m_ov = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        eg = (m_state != 0) ? (N'(1) << m_idx) : '0;
        chk("rnd.grant", 32'(grant), 32'(eg));
        chk("rnd.grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("rnd.grant_valid", 32'(grant_valid), 32'(m_state == 1));
        chk("rnd.drain", 32'(drain), 32'(m_state == 2));
        chk("rnd.oversize", 32'(oversize), 32'(m_ov));
        chk("rnd.oversize_count", 32'(oversize_count), 32'(m_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int n_ov, n_dr, ov_beat;
        int pos[N];
        int gq[$];
        int exp_rr[7];
        logic [N-1:0] act, acc;
        logic prev_gv, added;

        do_reset();
        chk_all("reset", '0, 0, 1'b0, 1'b0, 1'b0);
        chk("reset.oversize_count", 32'(oversize_count), 32'd0);

        // {port_en, req, req_last, dst_ready} -> {grant, grant_idx, grant_valid, drain, oversize}
        tbl.push_back(mk(24'hFFFFFF, 24'h000021, 24'h000021, 1'b1, 24'h000001, 5'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFFF, 24'h000021, 24'h000021, 1'b1, 24'h000000, 5'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFFF, 24'h000020, 24'h000020, 1'b1, 24'h000020, 5'd5, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFFF, 24'h000020, 24'h000020, 1'b1, 24'h000000, 5'd5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFBF, 24'h000040, 24'h000040, 1'b1, 24'h000000, 5'd5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFBF, 24'h000040, 24'h000040, 1'b1, 24'h000000, 5'd5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFFBF, 24'h000240, 24'h000000, 1'b1, 24'h000200, 5'd9, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFDBF, 24'h000040, 24'h000200, 1'b1, 24'h000200, 5'd9, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFDBF, 24'h000240, 24'h000000, 1'b1, 24'h000200, 5'd9, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFDBF, 24'h000240, 24'h000200, 1'b1, 24'h000000, 5'd9, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFDBF, 24'h000240, 24'h000000, 1'b1, 24'h000000, 5'd9, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24'hFFFDBF, 24'h000240, 24'h000000, 1'b1, 24'h000000, 5'd9, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < tbl.size(); i++) begin
            port_en = tbl[i].en; req = tbl[i].rq; req_last = tbl[i].lst; dst_ready = tbl[i].rdy;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].eg, int'(tbl[i].eidx), tbl[i].egv, tbl[i].edr, tbl[i].eov);
        end

        // Backpressure on port 2 for 10 cycles, then an exact-max 8-beat frame.
        port_en = '1; req = 24'h000004; req_last = '0; dst_ready = 1'b0;
        tick();
        chk_all("bp.grant", 24'h000004, 2, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_all($sformatf("bp.hold%0d", c), 24'h000004, 2, 1'b1, 1'b0, 1'b0);
        end
        dst_ready = 1'b1; n_ov = 0; n_dr = 0;
        for (int b = 1; b <= MAXB; b++) begin
            req_last = (b == MAXB) ? 24'h000004 : '0;
            tick();
            if (oversize) n_ov++;
            if (drain) n_dr++;
        end
        chk("exact.oversize_pulses", 32'(n_ov), 32'd0);
        chk("exact.drain_cycles", 32'(n_dr), 32'd0);
        chk_all("exact.end", '0, 2, 1'b0, 1'b0, 1'b0);

        // Oversize: 10-beat frame on port 4.
        req = 24'h000010; req_last = '0; dst_ready = 1'b1;
        tick();
        chk_all("ov.grant", 24'h000010, 4, 1'b1, 1'b0, 1'b0);
        n_ov = 0; ov_beat = 0;
        for (int b = 1; b <= 10; b++) begin
            dst_ready = (b <= MAXB);
            req_last  = (b == 10) ? 24'h000010 : '0;
            if (b <= MAXB) chk($sformatf("ov.gv_beat%0d", b), 32'(grant_valid), 32'd1);
            else           chk($sformatf("ov.drain_beat%0d", b), 32'(drain), 32'd1);
            tick();
            if (oversize) begin n_ov++; ov_beat = b; end
        end
        chk("ov.pulses", 32'(n_ov), 32'd1);
        chk("ov.pulse_beat", 32'(ov_beat), 32'(MAXB));
        chk("ov.count", 32'(oversize_count), 32'd1);
        chk_all("ov.end", '0, 4, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame on port 1.
        req = 24'h000002; req_last = '0; dst_ready = 1'b0;
        tick();
        chk_all("mid.grant", 24'h000002, 1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("mid.rst", '0, 0, 1'b0, 1'b0, 1'b0);
        chk("mid.rst_count", 32'(oversize_count), 32'd0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        tick();
        chk_all("mid.after", '0, 0, 1'b0, 1'b0, 1'b0);

        // Round robin with wrap: ports 3,7,23 with 4-beat frames; port 0 joins once 23 is granted.
        do_reset();
        exp_rr = '{3, 7, 23, 0, 3, 7, 23};
        act = (N'(1) << 3) | (N'(1) << 7) | (N'(1) << 23);
        for (int p = 0; p < N; p++) pos[p] = 0;
        prev_gv = 1'b0; added = 1'b0; dst_ready = 1'b1;
        for (int c = 0; c < 200 && gq.size() < 7; c++) begin
            req = act;
            for (int p = 0; p < N; p++) req_last[IW'(p)] = act[IW'(p)] && (pos[p] == 3);
            acc = grant_valid ? (grant & req) : '0;
            tick();
            for (int p = 0; p < N; p++) if (acc[IW'(p)]) pos[p] = (pos[p] == 3) ? 0 : pos[p] + 1;
            if (grant_valid && !prev_gv) begin
                gq.push_back(int'(grant_idx));
                if (grant_idx == 5'd23 && !added) begin act[0] = 1'b1; added = 1'b1; end
            end
            prev_gv = grant_valid;
        end
        chk("rr.grants_seen", 32'(gq.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("rr.order%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));

        // Random traffic with bubbles, port_en churn and backpressure against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            model_check();
            for (int p = 0; p < N; p++) begin
                if (flen[p] == 0 && $urandom_range(0, 3) == 0) begin
                    flen[p] = $urandom_range(1, 12); fpos[p] = 0;
                end
                req[IW'(p)] = (flen[p] != 0) && ($urandom_range(0, 5) != 0);
                req_last[IW'(p)] = req[IW'(p)] ? (fpos[p] == flen[p] - 1) : ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 15) == 0) port_en[IW'(p)] = ~port_en[IW'(p)];
            end
            dst_ready = ($urandom_range(0, 3) != 0);
            model_step();
            tick();
        end
        model_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
